// File: rtl/tcp_segment_tx_if.sv
// Bundle of the payload-in, send-request and segment-out signals of the TCP
// transmit segment builder. The slave side is the builder itself.
`ifndef MII_DATA_WIDTH
`define MII_DATA_WIDTH 4
`endif

interface tcp_segment_tx_if;
  logic                       i_data_vld;
  logic [`MII_DATA_WIDTH-1:0] i_data;
  logic                       o_data_ready;
  logic                       i_send_req;
  logic [31:0]                i_seq_num;
  logic [31:0]                i_ack_num;
  logic [5:0]                 i_flags;
  logic [15:0]                i_window;
  logic                       o_busy;
  logic                       o_segment_req;
  logic                       i_segment_gnt;
  logic                       o_segment_vld;
  logic [`MII_DATA_WIDTH-1:0] o_segment_data;
  logic [15:0]                o_segment_len_b;
  logic [31:0]                o_dst_ip;
  logic                       o_done;

  modport slave (
    input  i_data_vld, i_data, i_send_req, i_seq_num, i_ack_num, i_flags,
           i_window, i_segment_gnt,
    output o_data_ready, o_busy, o_segment_req, o_segment_vld,
           o_segment_data, o_segment_len_b, o_dst_ip, o_done
  );

  modport master (
    output i_data_vld, i_data, i_send_req, i_seq_num, i_ack_num, i_flags,
           i_window, i_segment_gnt,
    input  o_data_ready, o_busy, o_segment_req, o_segment_vld,
           o_segment_data, o_segment_len_b, o_dst_ip, o_done
  );
endinterface

// File: rtl/tcp_segment_tx.sv
// TCP transmit segment builder for a single client socket.
// Buffers payload nibbles, accumulates the one's-complement checksum while
// they arrive, then on request finishes the checksum and streams
// header + payload as an MSB-first nibble stream.
//
// state | meaning
// ------+----------------------------------------------------------
// IDLE  | accepting payload nibbles, waiting for a send request
// CSUM  | 20 cycles folding pseudo-header, header and odd byte into sum
// REQ   | requesting the IP-layer slot, waiting for grant
// HDR   | streaming the 40 header nibbles
// PAY   | streaming the 2N buffered payload nibbles
`ifndef MII_DATA_WIDTH
`define MII_DATA_WIDTH 4
`endif

module tcp_segment_tx #(
  parameter logic [31:0] FPGA_IP       = 32'hC0A80100,
  parameter logic [15:0] FPGA_PORT     = 16'h5487,
  parameter logic [31:0] TWSE_IP       = 32'hEA006464,
  parameter logic [15:0] TWSE_PORT     = 16'h2714,
  parameter int          MAX_PAYLOAD_B = 64
) (
  input  logic              i_sys_clk,
  input  logic              i_rst,
  tcp_segment_tx_if.slave   seg
);

  localparam int BUF_NIB = 2 * MAX_PAYLOAD_B;
  localparam int AW      = $clog2(BUF_NIB);
  localparam int CW      = AW + 1;
  localparam int IDX_W   = AW + 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CSUM,
    S_REQ,
    S_HDR,
    S_PAY
  } state_t;

  state_t state_q, state_d;

  logic [IDX_W-1:0] idx_q, idx_d;
  logic             vld_q, vld_d;
  logic [3:0]       data_q, data_d;
  logic             req_q, req_d;
  logic             done_q, done_d;
  logic             busy_q, busy_d;

  logic [3:0]       buf_mem [BUF_NIB];
  logic [CW-1:0]    nib_cnt_q;
  logic [CW-1:0]    cnt_eff;
  logic [11:0]      word_sr_q;
  logic [15:0]      acc_q;
  logic [AW-1:0]    n_bytes_q;
  logic [31:0]      seq_q;
  logic [31:0]      ack_q;
  logic [5:0]       flags_q;
  logic [15:0]      win_q;
  logic [15:0]      len_q;

  logic             full;
  logic             data_ready;
  logic             wr_en;
  logic             accept;
  logic [IDX_W-1:0] pay_last;
  logic [IDX_W-1:0] idx_nxt;
  logic [7:0]       pend_byte;
  logic [15:0]      csum_word;
  logic [159:0]     hdr_vec;

  function automatic logic [15:0] ones_add(input logic [15:0] a, input logic [15:0] b);
    logic [16:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[15:0] + {15'd0, s[16]};
  endfunction

  assign full       = (nib_cnt_q == CW'(BUF_NIB));
  assign data_ready = (state_q == S_IDLE) && !full && !i_rst;
  assign wr_en      = seg.i_data_vld && data_ready;
  assign accept     = (state_q == S_IDLE) && seg.i_send_req;
  assign cnt_eff    = nib_cnt_q + CW'(wr_en);
  assign pay_last   = {n_bytes_q, 1'b0} - IDX_W'(1);
  assign idx_nxt    = idx_q + IDX_W'(1);
  assign pend_byte  = {buf_mem[pay_last[AW-1:0] - AW'(1)], buf_mem[pay_last[AW-1:0]]};

  // Header image; the checksum field carries the finished sum once CSUM is over.
  assign hdr_vec = {FPGA_PORT, TWSE_PORT, seq_q, ack_q, 4'h5, 4'h0, 2'b00, flags_q,
                    win_q, ~acc_q, 16'h0000};

  assign seg.o_data_ready    = data_ready;
  assign seg.o_busy          = busy_q;
  assign seg.o_segment_req   = req_q;
  assign seg.o_segment_vld   = vld_q;
  assign seg.o_segment_data  = data_q;
  assign seg.o_segment_len_b = len_q;
  assign seg.o_dst_ip        = TWSE_IP;
  assign seg.o_done          = done_q;

  // Word folded into the sum on each CSUM cycle; the checksum field counts as zero.
  always_comb begin
    csum_word = 16'h0000;
    case (int'(idx_q))
      0:       csum_word = FPGA_IP[31:16];
      1:       csum_word = FPGA_IP[15:0];
      2:       csum_word = TWSE_IP[31:16];
      3:       csum_word = TWSE_IP[15:0];
      4:       csum_word = 16'h0006;
      5:       csum_word = len_q;
      6:       csum_word = FPGA_PORT;
      7:       csum_word = TWSE_PORT;
      8:       csum_word = seq_q[31:16];
      9:       csum_word = seq_q[15:0];
      10:      csum_word = ack_q[31:16];
      11:      csum_word = ack_q[15:0];
      12:      csum_word = {4'h5, 4'h0, 2'b00, flags_q};
      13:      csum_word = win_q;
      16:      csum_word = n_bytes_q[0] ? {pend_byte, 8'h00} : 16'h0000;
      default: csum_word = 16'h0000;
    endcase
  end

  // Next-state and next registered-output logic.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    vld_d   = 1'b0;
    data_d  = 4'h0;
    req_d   = 1'b0;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (seg.i_send_req) begin
          state_d = S_CSUM;
          idx_d   = '0;
        end
      end
      S_CSUM: begin
        if (int'(idx_q) == 19) begin
          state_d = S_REQ;
          req_d   = 1'b1;
          idx_d   = '0;
        end else begin
          idx_d = idx_nxt;
        end
      end
      S_REQ: begin
        req_d = 1'b1;
        if (seg.i_segment_gnt) begin
          state_d = S_HDR;
          req_d   = 1'b0;
          vld_d   = 1'b1;
          data_d  = hdr_vec[159:156];
          idx_d   = '0;
        end
      end
      S_HDR: begin
        vld_d = 1'b1;
        if (int'(idx_q) >= 39) begin
          idx_d = '0;
          if (n_bytes_q != '0) begin
            state_d = S_PAY;
            data_d  = buf_mem[0];
          end else begin
            state_d = S_IDLE;
            vld_d   = 1'b0;
            done_d  = 1'b1;
          end
        end else begin
          idx_d  = idx_nxt;
          data_d = hdr_vec[(39 - int'(idx_nxt)) * 4 +: 4];
        end
      end
      S_PAY: begin
        vld_d = 1'b1;
        if (idx_q == pay_last) begin
          state_d = S_IDLE;
          vld_d   = 1'b0;
          done_d  = 1'b1;
          idx_d   = '0;
        end else begin
          idx_d  = idx_nxt;
          data_d = buf_mem[idx_nxt[AW-1:0]];
        end
      end
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE);
  end

  // FSM state and registered segment-side outputs.
  always_ff @(posedge i_sys_clk) begin
    if (i_rst) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      vld_q   <= 1'b0;
      data_q  <= 4'h0;
      req_q   <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      vld_q   <= vld_d;
      data_q  <= data_d;
      req_q   <= req_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
    end
  end

  // Payload storage; contents are don't-care beyond nib_cnt so no reset.
  always_ff @(posedge i_sys_clk) begin
    if (wr_en) begin
      buf_mem[nib_cnt_q[AW-1:0]] <= seg.i_data;
    end
  end

  // Fill count, running checksum and request fields latched on accept.
  always_ff @(posedge i_sys_clk) begin
    if (i_rst) begin
      nib_cnt_q <= '0;
      word_sr_q <= '0;
      acc_q     <= '0;
      n_bytes_q <= '0;
      seq_q     <= '0;
      ack_q     <= '0;
      flags_q   <= '0;
      win_q     <= '0;
      len_q     <= '0;
    end else begin
      if (wr_en) begin
        nib_cnt_q <= nib_cnt_q + CW'(1);
        word_sr_q <= {word_sr_q[7:0], seg.i_data};
        if (nib_cnt_q[1:0] == 2'b11) begin
          acc_q <= ones_add(acc_q, {word_sr_q, seg.i_data});
        end
      end
      if (accept) begin
        seq_q     <= seg.i_seq_num;
        ack_q     <= seg.i_ack_num;
        flags_q   <= seg.i_flags;
        win_q     <= seg.i_window;
        n_bytes_q <= cnt_eff[CW-1:1];
        len_q     <= 16'd20 + 16'(cnt_eff[CW-1:1]);
      end
      if (state_q == S_CSUM) begin
        acc_q <= ones_add(acc_q, csum_word);
      end
      if (done_d) begin
        nib_cnt_q <= '0;
        word_sr_q <= '0;
        acc_q     <= '0;
      end
    end
  end

endmodule

// File: tb/tb_tcp_segment_tx.sv
// Directed bench for tcp_segment_tx: drives payload and send requests,
// captures the nibble stream and compares against a software checksum model
// and hand-computed values.
`ifndef MII_DATA_WIDTH
`define MII_DATA_WIDTH 4
`endif

module tb_tcp_segment_tx;

  logic clk = 1'b0;
  logic rst;
  int   n_vec = 0;
  int   n_err = 0;

  logic [7:0] pay_b [64];
  logic [3:0] got_q [$];
  int         got_vld;

  tcp_segment_tx_if sif ();

  tcp_segment_tx dut (
    .i_sys_clk (clk),
    .i_rst     (rst),
    .seg       (sif)
  );

  // Free-running system clock.
  always #5 clk = ~clk;

  task automatic chk_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [3:0] pay_nib(input int k);
    logic [7:0] b;
    b = pay_b[k >> 1];
    return k[0] ? b[3:0] : b[7:4];
  endfunction

  function automatic logic [15:0] model_csum(input logic [31:0] seq, input logic [31:0] ack,
                                              input logic [5:0] fl, input logic [15:0] win,
                                              input int nb);
    logic [31:0] s;
    logic [7:0]  lo;
    s = 32'hC0A8 + 32'h0100 + 32'hEA00 + 32'h6464 + 32'h0006 + 32'(20 + nb);
    s = s + 32'h5487 + 32'h2714 + {16'h0, seq[31:16]} + {16'h0, seq[15:0]}
          + {16'h0, ack[31:16]} + {16'h0, ack[15:0]} + {16'h0, 8'h50, 2'b00, fl}
          + {16'h0, win};
    for (int i = 0; i < nb; i += 2) begin
      lo = (i + 1 < nb) ? pay_b[i + 1] : 8'h00;
      s  = s + {16'h0, pay_b[i], lo};
    end
    while (s[31:16] != 16'h0) s = {16'h0, s[15:0]} + {16'h0, s[31:16]};
    return ~s[15:0];
  endfunction

  function automatic logic [15:0] got_csum();
    if (got_q.size() < 36) return 16'h0;
    return {got_q[32], got_q[33], got_q[34], got_q[35]};
  endfunction

  task automatic wr_nib(input logic [3:0] d);
    sif.i_data_vld = 1'b1;
    sif.i_data     = d;
    @(negedge clk);
    sif.i_data_vld = 1'b0;
  endtask

  task automatic wr_nibs(input int cnt);
    for (int i = 0; i < cnt; i++) wr_nib(pay_nib(i));
  endtask

  task automatic send(input logic [31:0] seq, input logic [31:0] ack, input logic [5:0] fl,
                      input logic [15:0] win, input bit with_nib, input logic [3:0] nib);
    sif.i_seq_num  = seq;
    sif.i_ack_num  = ack;
    sif.i_flags    = fl;
    sif.i_window   = win;
    sif.i_send_req = 1'b1;
    if (with_nib) begin
      sif.i_data_vld = 1'b1;
      sif.i_data     = nib;
    end
    @(negedge clk);
    sif.i_send_req = 1'b0;
    sif.i_data_vld = 1'b0;
  endtask

  // Called on the first negedge after the request edge.
  task automatic run_seg(input int gnt_dly, input int dup_at, input int rst_at, input int exp_len);
    int w;
    int rc;
    int n;
    got_q.delete();
    chk_eq("busy_after_req", sif.o_busy, 1);
    chk_eq("len_in_csum", sif.o_segment_len_b, exp_len);
    w = 0;
    while (!sif.o_segment_req && w < 100) begin
      @(negedge clk);
      w++;
    end
    chk_eq("csum_latency", w, 20);
    rc = 0;
    while (sif.o_segment_req && rc < 50) begin
      if (rc == gnt_dly) sif.i_segment_gnt = 1'b1;
      @(negedge clk);
      sif.i_segment_gnt = 1'b0;
      rc++;
    end
    chk_eq("req_cycles", rc, gnt_dly + 1);
    chk_eq("first_nib_vld", sif.o_segment_vld, 1);
    n = 0;
    while (sif.o_segment_vld && n < 400) begin
      got_q.push_back(sif.o_segment_data);
      if (n == dup_at) begin
        sif.i_send_req = 1'b1;
        sif.i_seq_num  = 32'hDEADBEEF;
        sif.i_flags    = 6'b111111;
      end
      if (n == rst_at) rst = 1'b1;
      @(negedge clk);
      sif.i_send_req = 1'b0;
      if (n == dup_at) chk_eq("busy_dup_req", sif.o_busy, 1);
      if (n == rst_at) begin
        chk_eq("rst_vld", sif.o_segment_vld, 0);
        chk_eq("rst_busy", sif.o_busy, 0);
        chk_eq("rst_ready", sif.o_data_ready, 0);
        rst = 1'b0;
        @(negedge clk);
        chk_eq("ready_after_rst", sif.o_data_ready, 1);
        got_vld = n + 1;
        return;
      end
      n++;
    end
    got_vld = n;
    chk_eq("done_pulse", sif.o_done, 1);
    chk_eq("busy_fall", sif.o_busy, 0);
    chk_eq("len_at_done", sif.o_segment_len_b, exp_len);
    @(negedge clk);
    chk_eq("done_single", sif.o_done, 0);
  endtask

  task automatic check_stream(input string tag, input logic [31:0] seq, input logic [31:0] ack,
                              input logic [5:0] fl, input logic [15:0] win, input int nb);
    logic [159:0] hdr;
    logic [15:0]  cs;
    logic [3:0]   e;
    int           total;
    cs    = model_csum(seq, ack, fl, win, nb);
    hdr   = {16'h5487, 16'h2714, seq, ack, 4'h5, 4'h0, 2'b00, fl, win, cs, 16'h0000};
    total = 40 + 2 * nb;
    chk_eq({tag, "_vld_cycles"}, got_vld, total);
    chk_eq({tag, "_nibs"}, got_q.size(), total);
    for (int i = 0; i < got_q.size() && i < total; i++) begin
      if (i < 40) e = hdr[(39 - i) * 4 +: 4];
      else        e = pay_nib(i - 40);
      chk_eq($sformatf("%s_n%0d", tag, i), got_q[i], e);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst               = 1'b1;
    sif.i_data_vld    = 1'b0;
    sif.i_data        = 4'h0;
    sif.i_send_req    = 1'b0;
    sif.i_seq_num     = '0;
    sif.i_ack_num     = '0;
    sif.i_flags       = '0;
    sif.i_window      = '0;
    sif.i_segment_gnt = 1'b0;
    got_vld           = 0;

    repeat (3) @(negedge clk);
    chk_eq("rst_seg_vld", sif.o_segment_vld, 0);
    chk_eq("rst_seg_req", sif.o_segment_req, 0);
    chk_eq("rst_done", sif.o_done, 0);
    chk_eq("rst_busy0", sif.o_busy, 0);
    chk_eq("rst_data", sif.o_segment_data, 0);
    chk_eq("rst_len", sif.o_segment_len_b, 0);
    chk_eq("rst_dst_ip", sif.o_dst_ip, 32'hEA006464);
    chk_eq("rst_ready0", sif.o_data_ready, 0);
    rst = 1'b0;
    @(negedge clk);
    chk_eq("ready_first_idle", sif.o_data_ready, 1);

    // SYN, no payload, immediate grant
    send(32'h00001000, 32'h0, 6'b000010, 16'hFFFF, 1'b0, 4'h0);
    run_seg(0, -1, -1, 20);
    check_stream("syn", 32'h00001000, 32'h0, 6'b000010, 16'hFFFF, 0);
    chk_eq("syn_csum_hand", got_csum(), 16'h143A);

    // "HELLO" payload, ACK|PSH
    pay_b[0] = 8'h48; pay_b[1] = 8'h45; pay_b[2] = 8'h4C; pay_b[3] = 8'h4C; pay_b[4] = 8'h4F;
    wr_nibs(10);
    send(32'h00001001, 32'h00000001, 6'b011000, 16'h0400, 1'b0, 4'h0);
    run_seg(0, -1, -1, 25);
    check_stream("hello", 32'h00001001, 32'h00000001, 6'b011000, 16'h0400, 5);
    chk_eq("hello_csum_hand", got_csum(), 16'h2C8B);
    chk_eq("hello_last_nib", (got_q.size() == 50) ? got_q[49] : 4'h0, 4'hF);

    // Delayed grant, duplicate request during HDR ignored
    send(32'hAABBCCDD, 32'h11223344, 6'b010000, 16'h1234, 1'b0, 4'h0);
    run_seg(7, 10, -1, 20);
    check_stream("dly", 32'hAABBCCDD, 32'h11223344, 6'b010000, 16'h1234, 0);
    chk_eq("idle_after_dup", sif.o_busy, 0);

    // Full buffer: 128 nibbles accepted, 129th dropped
    for (int i = 0; i < 64; i++) pay_b[i] = 8'(i * 37 + 5);
    wr_nibs(127);
    chk_eq("ready_at_127", sif.o_data_ready, 1);
    wr_nib(pay_nib(127));
    chk_eq("ready_full", sif.o_data_ready, 0);
    wr_nib(4'h7);
    send(32'h01020304, 32'h05060708, 6'b011000, 16'h0800, 1'b0, 4'h0);
    run_seg(2, -1, -1, 84);
    check_stream("full", 32'h01020304, 32'h05060708, 6'b011000, 16'h0800, 64);

    // Odd count: 7 nibbles, trailing nibble discarded
    pay_b[0] = 8'h9C; pay_b[1] = 8'h3E; pay_b[2] = 8'hB1;
    wr_nibs(6);
    wr_nib(4'hA);
    send(32'h7FFFFFFF, 32'h80000000, 6'b011001, 16'h00FF, 1'b0, 4'h0);
    run_seg(1, -1, -1, 23);
    check_stream("odd", 32'h7FFFFFFF, 32'h80000000, 6'b011001, 16'h00FF, 3);

    // Nibble written in the request cycle is included
    pay_b[0] = 8'hD2; pay_b[1] = 8'h6B;
    wr_nibs(3);
    send(32'h00000010, 32'h00000020, 6'b010000, 16'h2000, 1'b1, pay_nib(3));
    run_seg(0, -1, -1, 22);
    check_stream("samecyc", 32'h00000010, 32'h00000020, 6'b010000, 16'h2000, 2);

    // Reset mid-PAY, then an empty-buffer request
    pay_b[0] = 8'h11; pay_b[1] = 8'h22; pay_b[2] = 8'h33; pay_b[3] = 8'h44;
    wr_nibs(8);
    send(32'h00000100, 32'h00000200, 6'b011000, 16'h0100, 1'b0, 4'h0);
    run_seg(0, -1, 44, 24);
    chk_eq("rst_trunc_nibs", got_vld, 45);
    send(32'h00000005, 32'h00000006, 6'b010000, 16'h4000, 1'b0, 4'h0);
    run_seg(0, -1, -1, 20);
    check_stream("post_rst", 32'h00000005, 32'h00000006, 6'b010000, 16'h4000, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/tcp_segment_tx.md
# tcp_segment_tx

Transmit-side TCP segment builder for one client socket (FPGA_IP:FPGA_PORT ↔ TWSE_IP:TWSE_PORT). It buffers an application payload and accepts a send request carrying seq/ack/flags/window from the socket control logic. It computes the TCP checksum over the pseudo-header, header and payload, then streams the full segment to the IP layer as a contiguous MSB-first nibble stream. That stream is the same format the TCP receive path parses.

## Interface
- FPGA_IP, 32'hC0A80100, local IP (pseudo-header source).
- FPGA_PORT, 16'h5487, local TCP port (source port field).
- TWSE_IP, 32'hEA006464, remote IP (pseudo-header destination, o_dst_ip).
- TWSE_PORT, 16'h2714, remote TCP port (destination port field).
- MAX_PAYLOAD_B, 64, payload buffer capacity in bytes (buffer = 2*MAX_PAYLOAD_B nibbles).

- i_sys_clk  in  1  system clock; sole clock.
- i_rst  in  1  synchronous, active-high reset.
- i_data_vld  in  1  payload nibble strobe from application.
- i_data  in  `MII_DATA_WIDTH (4)  payload nibble, high nibble of each byte first.
- o_data_ready  out  1  buffer accepts a nibble this cycle.
- i_send_req  in  1  one-cycle request to build/send a segment.
- i_seq_num  in  32  sequence number, sampled with i_send_req.
- i_ack_num  in  32  acknowledgment number, sampled with i_send_req.
- i_flags  in  6  {URG,ACK,PSH,RST,SYN,FIN}, sampled with i_send_req.
- i_window  in  16  window, sampled with i_send_req.
- o_busy  out  1  high from the accepted request through o_done.
- o_segment_req  out  1  request IP-layer slot.
- i_segment_gnt  in  1  IP layer grants slot.
- o_segment_vld  out  1  segment nibble valid.
- o_segment_data  out  `MII_DATA_WIDTH (4)  segment nibble.
- o_segment_len_b  out  16  TCP segment length in bytes (20 + payload).
- o_dst_ip  out  32  constant TWSE_IP.
- o_done  out  1  one-cycle pulse after the last nibble.

## Operation
- FSM states: IDLE, CSUM, REQ, HDR, PAY.
- IDLE:
  - o_data_ready = ~full.
  - Each i_data_vld with ready writes the nibble to the buffer and increments nib_cnt.
  - Writes while full or not IDLE are dropped.
  - Payload 16-bit words are accumulated into the checksum as they complete, with end-around carry.
- Request acceptance:
  - i_send_req in IDLE latches seq/ack/flags/window and sets N = nib_cnt>>1 payload bytes.
  - An odd trailing nibble is discarded.
  - A nibble written in the same cycle as the request is included.
  - State goes to CSUM.
  - i_send_req outside IDLE is ignored.
- CSUM: exactly 20 cycles, then REQ. It folds in the following, all as one's-complement 16-bit sum with end-around carry:
  - Pseudo-header: FPGA_IP hi/lo, TWSE_IP hi/lo, 16'h0006, 20+N.
  - The 10 header words, with the checksum field = 0.
  - A pending odd payload byte as {byte,8'h00}.
  - Checksum = ~sum. It is transmitted as computed, including 0x0000.
- REQ: o_segment_req held high until i_segment_gnt is sampled high, then HDR.
- HDR: 40 nibbles, MSB-first per field:
  - Nibbles 0-3: FPGA_PORT.
  - Nibbles 4-7: TWSE_PORT.
  - Nibbles 8-15: seq.
  - Nibbles 16-23: ack.
  - Nibble 24: 4'h5 (data offset).
  - Nibble 25: 4'h0.
  - Nibble 26: {2'b00, flags[5:4]}.
  - Nibble 27: flags[3:0].
  - Nibbles 28-31: window.
  - Nibbles 32-35: checksum.
  - Nibbles 36-39: 4'h0 (urgent pointer).
- PAY: 2N buffer nibbles in write order. PAY is skipped when N = 0.
- End of segment: o_segment_vld drops, o_done pulses, the buffer and checksum accumulator are cleared, and the FSM returns to IDLE.
- o_segment_len_b = 20+N and is stable from CSUM until o_done. o_dst_ip is constant.

## Timing
- Reset values:
  - o_segment_vld, o_segment_req, o_done, o_busy = 0.
  - o_segment_data = 0.
  - o_segment_len_b = 0.
  - o_data_ready = 0 while i_rst is high, 1 in the first IDLE cycle after release.
  - o_dst_ip = TWSE_IP.
- All outputs are registered except o_data_ready.
- Request timing:
  - Request sampled at edge T → o_busy = 1 from T+1.
  - CSUM occupies T+1..T+20.
  - o_segment_req = 1 from T+21.
- Grant timing:
  - Grant sampled at edge G → first nibble on o_segment_vld at G+1.
  - o_segment_req = 0 from G+1.
- o_segment_vld is high for exactly 40+2N consecutive cycles, with no gaps.
- o_done is high in the cycle after the last nibble. o_busy falls in the same cycle.
- i_rst at any state: next edge returns to IDLE with reset values, and the buffer is emptied. A partial segment is simply truncated, with no trailer.
- Full buffer = 2*MAX_PAYLOAD_B nibbles. o_data_ready is low in that cycle, so N never exceeds MAX_PAYLOAD_B.

## Test plan
- SYN, no payload:
  - Stimulus: seq=0x00001000, ack=0, flags=6'b000010, window=0xFFFF, gnt immediately.
  - Response: 40 nibbles "5487 2714 00001000 00000000 5 0 0 2 FFFF cccc 0000", len=20.
  - cccc must match the software model.
  - Looping the stream into the TCP receive path gives checksum OK.
- Payload "HELLO" (10 nibbles), flags=6'b011000:
  - len=25, vld high 50 cycles.
  - Checksum must include the padded word 0x4F00.
  - o_done one cycle after the last nibble 4'hF.
- Full buffer: write 129 nibbles with MAX_PAYLOAD_B=64 → o_data_ready low after 128, 129th dropped, len=84.
- Grant delayed 7 cycles:
  - o_segment_req high 7+1 cycles, first nibble the cycle after gnt.
  - A second i_send_req during HDR is ignored, and o_busy stays high.
- Odd nibble count: 7 nibbles then request → N=3, len=23, 6 payload nibbles, the 7th is not transmitted.
- i_rst asserted mid-PAY:
  - Next cycle o_segment_vld=0 and o_busy=0.
  - A subsequent request with an empty buffer produces len=20 and a correct checksum.
